// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: symbol encoding, FSM state type and debounce default
package button_conditioner_pkg;

    localparam int unsigned DEB_CYCLES_DEF = 4;

    localparam logic [1:0] SYM_B0 = 2'b00;
    localparam logic [1:0] SYM_B1 = 2'b01;
    localparam logic [1:0] SYM_B2 = 2'b10;
    localparam logic [1:0] SYM_B3 = 2'b11;

    typedef enum logic [1:0] {IDLE, QUAL_P, HELD, QUAL_R} state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] encode(input logic [3:0] v);
        return v[3] ? SYM_B3 : v[2] ? SYM_B2 : v[1] ? SYM_B1 : SYM_B0;
    endfunction

endpackage

// File: rtl/button_conditioner_sync2.sv
// sync2: two-flop synchronizer for one asynchronous input
module sync2 (
    input  logic CLK,
    input  logic RESET_N,
    input  logic d,
    output logic q
);

    logic s1_q, s2_q;

    // shift the raw level through two flops to settle metastability
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces four buttons and emits one encoded symbol per accepted press.
// Macro BUTTON_DEBOUNCE_EN enables the DEB_CYCLES qualification; without it presses are taken on first sight.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       b3,
    input  logic       b2,
    input  logic       b1,
    input  logic       b0,
    output logic [1:0] sym,
    output logic       sym_valid,
    output logic       multi_err,
    output logic       busy
);

    logic [3:0] b_raw;
    logic [3:0] bs;

    assign b_raw = {b3, b2, b1, b0};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        sync2 u_sync (
            .CLK    (CLK),
            .RESET_N(RESET_N),
            .d      (b_raw[i]),
            .q      (bs[i])
        );
    end

    state_t     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [1:0] sym_q, sym_d;
    logic       sym_valid_q, sym_valid_d;
    logic       multi_err_q, multi_err_d;
    logic       busy_q;
    logic       fire;
    logic [3:0] fire_v;

`ifdef BUTTON_DEBOUNCE_EN
    localparam logic [7:0] DEB = 8'(DEB_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;

    // the capture sample counts as the first stable clock, so the counter tracks the extra ones
    assign cnt_inc = (cnt_q == DEB) ? cnt_q : cnt_q + 8'd1;
`endif

    // next-state, candidate capture and accept decision
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        sym_d       = sym_q;
        sym_valid_d = 1'b0;
        multi_err_d = 1'b0;
        fire        = 1'b0;
        fire_v      = cand_q;
`ifdef BUTTON_DEBOUNCE_EN
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (bs != 4'd0) begin
                cand_d = bs;
                cnt_d  = 8'd0;
                if (DEB_CYCLES == 1) begin
                    fire   = 1'b1;
                    fire_v = bs;
                end else begin
                    state_d = QUAL_P;
                end
            end
            QUAL_P: if (bs == 4'd0) begin
                state_d = IDLE;
            end else if (bs != cand_q) begin
                cand_d = bs;
                cnt_d  = 8'd0;
            end else if (cnt_inc == DEB - 8'd1) begin
                fire = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
            HELD: if (bs == 4'd0) begin
                cnt_d   = 8'd0;
                state_d = (DEB_CYCLES == 1) ? IDLE : QUAL_R;
            end
            QUAL_R: if (bs != 4'd0) begin
                state_d = HELD;
                cnt_d   = 8'd0;
            end else if (cnt_inc == DEB - 8'd1) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_inc;
            end
            default: state_d = IDLE;
        endcase
`else
        case (state_q)
            IDLE: if (bs != 4'd0) begin
                cand_d = bs;
                fire   = 1'b1;
                fire_v = bs;
            end
            HELD: if (bs == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`endif
        if (fire) begin
            state_d     = HELD;
            sym_valid_d = is_onehot(fire_v);
            multi_err_d = !is_onehot(fire_v);
            sym_d       = is_onehot(fire_v) ? encode(fire_v) : sym_q;
        end
    end

    // state and registered outputs, all cleared asynchronously
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            sym_q       <= SYM_B0;
            sym_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BUTTON_DEBOUNCE_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            multi_err_q <= multi_err_d;
            busy_q      <= (state_d != IDLE);
`ifdef BUTTON_DEBOUNCE_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign sym       = sym_q;
    assign sym_valid = sym_valid_q;
    assign multi_err = multi_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of button_conditioner in the build selected by BUTTON_DEBOUNCE_EN
module tb_button_conditioner;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] bv;
    logic [1:0] sym;
    logic       sym_valid, multi_err, busy;
    int         n_cmp = 0;
    int         n_err = 0;
    int         nv, nm;

    button_conditioner #(.DEB_CYCLES(4)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .b3       (bv[3]),
        .b2       (bv[2]),
        .b1       (bv[1]),
        .b0       (bv[0]),
        .sym      (sym),
        .sym_valid(sym_valid),
        .multi_err(multi_err),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick(1);
            nv += int'(sym_valid);
            nm += int'(multi_err);
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        bv      = 4'd0;
        #12;
        chk("rst_sym", 8'(sym), 8'd0);
        chk("rst_valid", 8'(sym_valid), 8'd0);
        chk("rst_merr", 8'(multi_err), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
`ifdef BUTTON_DEBOUNCE_EN
        bv = 4'b0010;
        tick(5);
        chk("b1_early", 8'(sym_valid), 8'd0);
        tick(1);
        chk("b1_valid", 8'(sym_valid), 8'd1);
        chk("b1_sym", 8'(sym), 8'd1);
        chk("b1_busy", 8'(busy), 8'd1);
        tick(1);
        chk("b1_pulse_end", 8'(sym_valid), 8'd0);
        tick(3);
        bv = 4'b0000;
        tick(5);
        chk("b1_rel_busy", 8'(busy), 8'd1);
        tick(1);
        chk("b1_rel_idle", 8'(busy), 8'd0);
        bv = 4'b0100;
        tick(1);
        bv = 4'b0000;
        tick(1);
        bv = 4'b0100;
        nv = 0;
        run(5);
        chk("b2_bounce_none", 8'(nv), 8'd0);
        tick(1);
        chk("b2_valid", 8'(sym_valid), 8'd1);
        chk("b2_sym", 8'(sym), 8'd2);
        nv = 0;
        run(10);
        chk("b2_single", 8'(nv), 8'd0);
        bv = 4'b0000;
        tick(8);
        bv = 4'b1001;
        nv = 0;
        nm = 0;
        run(8);
        chk("multi_err_cnt", 8'(nm), 8'd1);
        chk("multi_valid_cnt", 8'(nv), 8'd0);
        chk("multi_sym_kept", 8'(sym), 8'd2);
        chk("multi_busy", 8'(busy), 8'd1);
        bv = 4'b0000;
        tick(8);
        chk("multi_rel_idle", 8'(busy), 8'd0);
        for (int i = 0; i < 4; i++) begin
            bv = (i % 2 == 1) ? 4'b0100 : 4'b0010;
            nv = 0;
            run((i == 3) ? 20 : 8);
            chk("seq_count", 8'(nv), 8'd1);
            chk("seq_sym", 8'(sym), (i % 2 == 1) ? 8'd2 : 8'd1);
            bv = 4'b0000;
            tick(8);
        end
        bv = 4'b1000;
        tick(5);
        RESET_N = 1'b0;
        #1;
        chk("midrst_sym", 8'(sym), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick(5);
        chk("requal_early", 8'(sym_valid), 8'd0);
        tick(1);
        chk("requal_valid", 8'(sym_valid), 8'd1);
        chk("requal_sym", 8'(sym), 8'd3);
`else
        bv = 4'b0001;
        tick(2);
        chk("b0_early", 8'(sym_valid), 8'd0);
        tick(1);
        chk("b0_valid", 8'(sym_valid), 8'd1);
        chk("b0_sym", 8'(sym), 8'd0);
        chk("b0_busy", 8'(busy), 8'd1);
        tick(1);
        chk("b0_pulse_end", 8'(sym_valid), 8'd0);
        bv = 4'b0000;
        tick(3);
        chk("b0_rel_idle", 8'(busy), 8'd0);
        bv = 4'b0010;
        tick(1);
        bv = 4'b0000;
        tick(2);
        chk("glitch_valid", 8'(sym_valid), 8'd1);
        chk("glitch_sym", 8'(sym), 8'd1);
        tick(1);
        chk("glitch_end", 8'(sym_valid), 8'd0);
        chk("glitch_idle", 8'(busy), 8'd0);
        bv = 4'b1001;
        tick(3);
        chk("multi_err", 8'(multi_err), 8'd1);
        chk("multi_no_valid", 8'(sym_valid), 8'd0);
        chk("multi_sym_kept", 8'(sym), 8'd1);
        bv = 4'b0100;
        nv = 0;
        nm = 0;
        run(5);
        chk("held_ignore_v", 8'(nv), 8'd0);
        chk("held_ignore_m", 8'(nm), 8'd0);
        bv = 4'b0000;
        tick(3);
        chk("multi_rel_idle", 8'(busy), 8'd0);
        bv = 4'b1000;
        tick(2);
        RESET_N = 1'b0;
        #1;
        chk("midrst_sym", 8'(sym), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick(2);
        chk("requal_early", 8'(sym_valid), 8'd0);
        tick(1);
        chk("requal_valid", 8'(sym_valid), 8'd1);
        chk("requal_sym", 8'(sym), 8'd3);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
